// File: rtl/pattern_serializer_if.sv
// Load handshake and serial output bundle for pattern_serializer.
interface pattern_serializer_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, load_reps,
    input  load_ready, out, out_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_reps,
    output load_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/pattern_serializer.sv
// Serializes a captured WIDTH-bit pattern MSB-first, load_reps times,
// with GAP idle cycles between frames; all outputs registered.
module pattern_serializer #(
  parameter int WIDTH = 3,
  parameter int GAP   = 1,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pattern_serializer_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_dec;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  assign idx_dec = idx_q - 1'b1;

  // idx_q always names the bit currently on out; frames_q counts the
  // frame in flight, so the final frame is recognised at frames_q == 1.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    idx_d       = idx_q;
    frames_d    = frames_q;
    gap_d       = gap_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    ready_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.load_valid && ready_q) begin
          pattern_d = bus.load_data;
          frames_d  = bus.load_reps;
          if (bus.load_reps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_SHIFT;
            idx_d       = IDX_MSB;
            out_d       = bus.load_data[WIDTH-1];
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            ready_d     = 1'b0;
          end
        end
      end

      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d       = idx_dec;
          out_d       = pattern_q[idx_dec];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else if (frames_q <= CNT_W'(1)) begin
          state_d  = S_IDLE;
          frames_d = '0;
          done_d   = 1'b1;
          ready_d  = 1'b1;
        end else begin
          frames_d = frames_q - 1'b1;
          busy_d   = 1'b1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end else begin
            idx_d       = IDX_MSB;
            out_d       = pattern_q[WIDTH-1];
            out_valid_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          state_d     = S_SHIFT;
          idx_d       = IDX_MSB;
          out_d       = pattern_q[WIDTH-1];
          out_valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      idx_q       <= '0;
      frames_q    <= '0;
      gap_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      idx_q       <= idx_d;
      frames_q    <= frames_d;
      gap_q       <= gap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: one instance with GAP=1, one with GAP=0,
// plus a 101 detector fed from the GAP=1 instance's serial line.
module tb_pattern_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_serializer_if #(.WIDTH(3), .CNT_W(4)) if0 ();
  pattern_serializer_if #(.WIDTH(3), .CNT_W(4)) if1 ();

  pattern_serializer #(.WIDTH(3), .GAP(1), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  pattern_serializer #(.WIDTH(3), .GAP(0), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Overlapping 101 detector sharing clk/reset, input tied to the serial line.
  logic [2:0] sr;
  logic       det;
  always_ff @(posedge clk) begin
    if (!rst) sr <= 3'b000;
    else      sr <= {sr[1:0], if0.out};
  end
  assign det = (sr == 3'b101);

  int vectors = 0;
  int miscompares = 0;

  // Expected word per cycle: {out, out_valid, busy, done, load_ready}
  logic [4:0] exp_q[$];

  function automatic logic [4:0] observe(input bit sel);
    if (sel) return {if1.out, if1.out_valid, if1.busy, if1.done, if1.load_ready};
    else     return {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
  endfunction

  task automatic set_load(input bit sel, input logic v, input logic [2:0] d, input logic [3:0] r);
    if (sel) begin
      if1.load_valid = v; if1.load_data = d; if1.load_reps = r;
    end else begin
      if0.load_valid = v; if0.load_data = d; if0.load_reps = r;
    end
  endtask

  task automatic push_frames(input bit sel, input logic [2:0] data, input int reps, input bit tail);
    int gap;
    gap = sel ? 0 : 1;
    for (int f = 0; f < reps; f++) begin
      for (int b = 2; b >= 0; b--) exp_q.push_back({data[b], 1'b1, 1'b1, 1'b0, 1'b0});
      if (f < reps - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00011);
    if (tail) exp_q.push_back(5'b00001);
  endtask

  task automatic drive_load(input bit sel, input logic [2:0] d, input logic [3:0] r);
    @(negedge clk);
    set_load(sel, 1'b1, d, r);
    @(posedge clk);
    #1 set_load(sel, 1'b0, 3'b000, 4'd0);
  endtask

  task automatic run_expect(input bit sel, input string name, input int poke_at,
                            input logic [2:0] pd, input logic [3:0] pr);
    int i;
    logic [4:0] e, o;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (poke_at >= 0 && i == poke_at + 1) set_load(sel, 1'b0, 3'b000, 4'd0);
      e = exp_q.pop_front();
      o = observe(sel);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s[%0d]: out/vld/busy/done/rdy got %b expected %b", name, i, o, e);
      end
      if (i == poke_at) set_load(sel, 1'b1, pd, pr);
      i++;
    end
    set_load(sel, 1'b0, 3'b000, 4'd0);
  endtask

  task automatic test_reset();
    logic [4:0] o;
    rst = 1'b0;
    set_load(1'b0, 1'b1, 3'b101, 4'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = observe(s[0]);
      vectors++;
      if (o !== 5'b00001) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b expected %b", s, o, 5'b00001);
      end
    end
    set_load(1'b0, 1'b0, 3'b000, 4'd0);
    rst = 1'b1;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00001);
    run_expect(1'b0, "post_reset", -1, 3'b000, 4'd0);
  endtask

  task automatic test_single();
    push_frames(1'b0, 3'b101, 1, 1'b1);
    drive_load(1'b0, 3'b101, 4'd1);
    run_expect(1'b0, "single", -1, 3'b000, 4'd0);
  endtask

  task automatic test_repeat_gap();
    push_frames(1'b0, 3'b101, 2, 1'b1);
    drive_load(1'b0, 3'b101, 4'd2);
    run_expect(1'b0, "repeat_gap", -1, 3'b000, 4'd0);
  endtask

  task automatic test_no_gap();
    push_frames(1'b1, 3'b110, 3, 1'b1);
    drive_load(1'b1, 3'b110, 4'd3);
    run_expect(1'b1, "no_gap", -1, 3'b000, 4'd0);
  endtask

  task automatic test_loopback();
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (det !== 1'b0) begin
      miscompares++;
      $display("FAIL loopback_idle: det got %b expected 0", det);
    end
    drive_load(1'b0, 3'b101, 4'd2);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        vectors++;
        if (det !== 1'b0) begin
          miscompares++;
          $display("FAIL loopback_early[%0d]: det got %b expected 0", c, det);
        end
      end else if (c == 4 || c == 8) begin
        vectors++;
        if (det !== 1'b1) begin
          miscompares++;
          $display("FAIL loopback_frame[%0d]: det got %b expected 1", c, det);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b01100);
    drive_load(1'b0, 3'b101, 4'd2);
    run_expect(1'b0, "midframe_pre", -1, 3'b000, 4'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) exp_q.push_back(5'b00001);
    run_expect(1'b0, "midframe_abort", -1, 3'b000, 4'd0);
  endtask

  task automatic test_ignore_load();
    push_frames(1'b0, 3'b101, 1, 1'b1);
    drive_load(1'b0, 3'b101, 4'd1);
    run_expect(1'b0, "ignore_load", 1, 3'b010, 4'd3);
  endtask

  task automatic test_zero_reps();
    push_frames(1'b0, 3'b111, 0, 1'b1);
    exp_q.push_back(5'b00001);
    drive_load(1'b0, 3'b111, 4'd0);
    run_expect(1'b0, "zero_reps_gap1", -1, 3'b000, 4'd0);
    push_frames(1'b1, 3'b111, 0, 1'b1);
    drive_load(1'b1, 3'b111, 4'd0);
    run_expect(1'b1, "zero_reps_gap0", -1, 3'b000, 4'd0);
  endtask

  task automatic test_max_reps();
    push_frames(1'b0, 3'b011, 15, 1'b1);
    drive_load(1'b0, 3'b011, 4'd15);
    run_expect(1'b0, "max_reps_gap1", -1, 3'b000, 4'd0);
    push_frames(1'b1, 3'b100, 15, 1'b1);
    drive_load(1'b1, 3'b100, 4'd15);
    run_expect(1'b1, "max_reps_gap0", -1, 3'b000, 4'd0);
  endtask

  task automatic test_back_to_back();
    push_frames(1'b0, 3'b101, 1, 1'b0);
    push_frames(1'b0, 3'b110, 1, 1'b1);
    drive_load(1'b0, 3'b101, 4'd1);
    run_expect(1'b0, "back_to_back", 3, 3'b110, 4'd1);
  endtask

  initial begin
    rst = 1'b0;
    set_load(1'b0, 1'b0, 3'b000, 4'd0);
    set_load(1'b1, 1'b0, 3'b000, 4'd0);
    test_reset();
    test_single();
    test_repeat_gap();
    test_no_gap();
    test_loopback();
    test_reset_midframe();
    test_ignore_load();
    test_zero_reps();
    test_max_reps();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
